// File: rtl/i2c_slave.sv
// I2C target: oversampled sclk/sda, 7-bit address match, byte receive with ACK,
// byte transmit with master ACK/NACK handling. sda is open-drain (0 or 'z only).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ACK_ADDR = 4'd2,
    RX       = 4'd3,
    ACK_RX   = 4'd4,
    TX       = 4'd5,
    WAIT_ACK = 4'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;

  // One extra flop past the synchronizer keeps the previous synced sample for edge detection.
  logic [SYNC_STAGES:0] scl_sync_q, sda_sync_q;
  logic scl_now, scl_prev, sda_now, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-1:0], sclk};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-1:0], sda};
    end
  end

  assign scl_now   = scl_sync_q[SYNC_STAGES-1];
  assign scl_prev  = scl_sync_q[SYNC_STAGES];
  assign sda_now   = sda_sync_q[SYNC_STAGES-1];
  assign sda_prev  = sda_sync_q[SYNC_STAGES];
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: sda_oe_d = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_now};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = 4'd0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ACK_ADDR;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            bitcnt_d = 4'd0;
            if (rw_q) begin
              shift_d  = tx_data;
              tx_req_d = 1'b1;
              sda_oe_d = ~tx_data[7];
              state_d  = TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_now};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_now};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            bitcnt_d = 4'd0;
            state_d  = ACK_RX;
          end
        end
        ACK_RX: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = RX;
          end
        end
        TX: begin
          // bitcnt counts falls after bit7 was put on the bus; the 8th fall ends bit0.
          if (scl_fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        WAIT_ACK: begin
          if (scl_rise && sda_now) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (scl_fall) begin
            shift_d  = tx_data;
            tx_req_d = 1'b1;
            sda_oe_d = ~tx_data[7];
            bitcnt_d = 4'd0;
            state_d  = TX;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= 4'd0;
      rx_data_q  <= 8'h00;
      rw_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, bus monitor and a transaction-level
// reference model (address match decides ACK; written bytes appear on rx; read bytes equal tx).
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h42;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda_w;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  logic [3:0] state;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sda(sda_w), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int         rxv_cnt, txr_cnt, wide_cnt, slave_low_cnt, rxd_glitch;
  bit         busy_seen;
  logic [7:0] rx_q[$];
  logic [3:0] st_hist[$];
  logic       prev_rxv = 1'b0, prev_txr = 1'b0;
  logic [3:0] prev_st = 4'd0;
  logic [7:0] prev_rxd = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      prev_rxv = 1'b0; prev_txr = 1'b0; prev_st = 4'd0; prev_rxd = 8'h00;
    end else begin
      if (rx_valid) begin
        rxv_cnt++;
        rx_q.push_back(rx_data);
        if (prev_rxv) wide_cnt++;
      end else if (rx_data !== prev_rxd) rxd_glitch++;
      if (tx_req) begin
        txr_cnt++;
        if (prev_txr) wide_cnt++;
      end
      if (busy) busy_seen = 1'b1;
      if (sda_w === 1'b0 && !m_low) slave_low_cnt++;
      if (state !== prev_st) st_hist.push_back(state);
      prev_rxv = rx_valid; prev_txr = tx_req; prev_st = state; prev_rxd = rx_data;
    end
  end

  task automatic clr_mon();
    rxv_cnt = 0; txr_cnt = 0; wide_cnt = 0; slave_low_cnt = 0; rxd_glitch = 0;
    busy_seen = 1'b0;
    rx_q.delete();
    st_hist.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(4);
    sclk = 1'b1;  tick(4);
    m_low = 1'b1; tick(4);
    sclk = 1'b0;  tick(4);
  endtask

  task automatic i2c_stop();
    tick(4);
    m_low = 1'b1; tick(4);
    sclk = 1'b1;  tick(4);
    m_low = 1'b0; tick(8);
  endtask

  task automatic wbit(input logic b, output logic smp);
    tick(4);
    m_low = ~b; tick(4);
    sclk = 1'b1; tick(4);
    smp = sda_w; tick(4);
    sclk = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) wbit(b[i], s);
    wbit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(output logic [7:0] b, input logic mack, input logic [7:0] next_tx);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      wbit(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    wbit(~mack, s);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (rx_valid !== 1'b0 || tx_req !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got %b%b exp 00", rx_valid, tx_req); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    vectors++; if (sda_w !== 1'b1) begin miscompares++; $display("FAIL reset_sda got %b exp 1", sda_w); end
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_write();
    logic a1, a2;
    clr_mon();
    i2c_start();
    wbyte(8'h84, a1);
    wbyte(8'hA5, a2);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy_mid got %b exp 1", busy); end
    i2c_stop();
    vectors++; if ({a1, a2} !== 2'b11) begin miscompares++; $display("FAIL wr_acks got %b exp 11", {a1, a2}); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL wr_rx_data got %h exp a5", rx_data); end
    vectors++; if (rxv_cnt !== 1 || wide_cnt !== 0) begin miscompares++; $display("FAIL wr_rx_valid got cnt=%0d wide=%0d exp 1/0", rxv_cnt, wide_cnt); end
    vectors++; if (busy !== 1'b0 || state !== 4'd0) begin miscompares++; $display("FAIL wr_end got busy=%b state=%0d exp 0/0", busy, state); end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] b;
    logic [3:0] exp_st[5];
    exp_st = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd0};
    clr_mon();
    tx_data = 8'hF6;
    i2c_start();
    wbyte(8'h85, a);
    rbyte(b, 1'b0, 8'h00);
    i2c_stop();
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL rd_addr_ack got %b exp 1", a); end
    vectors++; if (b !== 8'hF6) begin miscompares++; $display("FAIL rd_byte got %h exp f6", b); end
    vectors++; if (txr_cnt !== 1 || wide_cnt !== 0) begin miscompares++; $display("FAIL rd_tx_req got cnt=%0d wide=%0d exp 1/0", txr_cnt, wide_cnt); end
    vectors++;
    if (st_hist.size() != 5) begin
      miscompares++; $display("FAIL rd_state_seq got %0d transitions exp 5", st_hist.size());
    end else begin
      for (int i = 0; i < 5; i++)
        if (st_hist[i] !== exp_st[i]) begin
          miscompares++; $display("FAIL rd_state_seq[%0d] got %0d exp %0d", i, st_hist[i], exp_st[i]);
          break;
        end
    end
  endtask

  task automatic test_mismatch();
    logic a1, a2;
    clr_mon();
    i2c_start();
    wbyte(8'h86, a1);
    wbyte(8'h11, a2);
    i2c_stop();
    vectors++; if ({a1, a2} !== 2'b00) begin miscompares++; $display("FAIL mm_acks got %b exp 00", {a1, a2}); end
    vectors++; if (slave_low_cnt !== 0) begin miscompares++; $display("FAIL mm_sda_low got %0d exp 0", slave_low_cnt); end
    vectors++; if (rxv_cnt !== 0 || busy_seen !== 1'b0) begin miscompares++; $display("FAIL mm_quiet got rxv=%0d busy=%b exp 0/0", rxv_cnt, busy_seen); end
  endtask

  task automatic test_multi_read_rstart();
    logic a1, a2, a3;
    logic [7:0] b1, b2;
    clr_mon();
    tx_data = 8'h12;
    i2c_start();
    wbyte(8'h85, a1);
    rbyte(b1, 1'b1, 8'h34);
    rbyte(b2, 1'b0, 8'h00);
    i2c_start();
    wbyte(8'h84, a2);
    wbyte(8'h5A, a3);
    i2c_stop();
    vectors++; if ({b1, b2} !== 16'h1234) begin miscompares++; $display("FAIL mr_bytes got %h%h exp 1234", b1, b2); end
    vectors++; if (txr_cnt !== 2) begin miscompares++; $display("FAIL mr_tx_req got %0d exp 2", txr_cnt); end
    vectors++; if ({a1, a2, a3} !== 3'b111) begin miscompares++; $display("FAIL mr_acks got %b exp 111", {a1, a2, a3}); end
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL mr_rx_data got %h exp 5a", rx_data); end
  endtask

  task automatic test_reset_mid_byte();
    logic a, s;
    tx_data = 8'hE5;
    i2c_start();
    wbyte(8'h85, a);
    for (int i = 0; i < 3; i++) wbit(1'b1, s);
    tick(4); m_low = 1'b0; tick(4); sclk = 1'b1; tick(4);
    vectors++; if (sda_w !== 1'b0) begin miscompares++; $display("FAIL rm_bit4_driven got %b exp 0", sda_w); end
    rst = 1'b0;
    #1;
    vectors++; if (sda_w !== 1'b1) begin miscompares++; $display("FAIL rm_sda_release got %b exp 1", sda_w); end
    vectors++; if (state !== 4'd0 || busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0 || tx_req !== 1'b0) begin
      miscompares++; $display("FAIL rm_outputs got st=%0d busy=%b rx=%h v=%b t=%b exp 0/0/00/0/0", state, busy, rx_data, rx_valid, tx_req);
    end
    sclk = 1'b0; tick(4);
    rst = 1'b1; tick(6);
    clr_mon();
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'hC3, s);
    i2c_stop();
    vectors++; if ({a, s} !== 2'b11 || rx_data !== 8'hC3 || rxv_cnt !== 1) begin
      miscompares++; $display("FAIL rm_after got acks=%b rx=%h rxv=%0d exp 11/c3/1", {a, s}, rx_data, rxv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [7:0] v[3];
    v = '{8'h00, 8'hFF, 8'h3C};
    clr_mon();
    i2c_start();
    wbyte(8'h84, a);
    for (int i = 0; i < 3; i++) begin
      wbyte(v[i], a);
      vectors++; if (a !== 1'b1 || rx_data !== v[i]) begin miscompares++; $display("FAIL b2b_byte%0d got ack=%b rx=%h exp 1/%h", i, a, rx_data, v[i]); end
    end
    i2c_stop();
    vectors++; if (rxv_cnt !== 3 || wide_cnt !== 0 || rxd_glitch !== 0) begin
      miscompares++; $display("FAIL b2b_pulses got cnt=%0d wide=%0d glitch=%0d exp 3/0/0", rxv_cnt, wide_cnt, rxd_glitch);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic       rd, match, ack;
    int         n;
    logic [7:0] v[4];
    logic [7:0] b, exp_b;
    logic [7:0] exp_q[$];
    for (int it = 0; it < 8; it++) begin
      a = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom);
      match = (a == ADDR);
      rd = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) v[k] = 8'($urandom);
      exp_q.delete();
      clr_mon();
      tx_data = v[0];
      i2c_start();
      wbyte({a, rd}, ack);
      vectors++; if (ack !== match) begin miscompares++; $display("FAIL rnd%0d_addr_ack got %b exp %b", it, ack, match); end
      if (!rd) begin
        for (int k = 0; k < n; k++) begin
          if (match) exp_q.push_back(v[k]);
          wbyte(v[k], ack);
          vectors++; if (ack !== match) begin miscompares++; $display("FAIL rnd%0d_wr_ack%0d got %b exp %b", it, k, ack, match); end
        end
        i2c_stop();
        vectors++;
        if (rx_q.size() != exp_q.size()) begin
          miscompares++; $display("FAIL rnd%0d_rx_count got %0d exp %0d", it, rx_q.size(), exp_q.size());
        end else begin
          for (int k = 0; k < exp_q.size(); k++)
            if (rx_q[k] !== exp_q[k]) begin
              miscompares++; $display("FAIL rnd%0d_rx%0d got %h exp %h", it, k, rx_q[k], exp_q[k]);
              break;
            end
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          rbyte(b, (k < n - 1), v[k + 1]);
          exp_b = match ? v[k] : 8'hFF;
          vectors++; if (b !== exp_b) begin miscompares++; $display("FAIL rnd%0d_rd%0d got %h exp %h", it, k, b, exp_b); end
        end
        i2c_stop();
        vectors++; if (txr_cnt !== (match ? n : 0)) begin miscompares++; $display("FAIL rnd%0d_tx_req got %0d exp %0d", it, txr_cnt, match ? n : 0); end
      end
      vectors++; if (busy !== 1'b0 || state !== 4'd0) begin miscompares++; $display("FAIL rnd%0d_end got busy=%b st=%0d exp 0/0", it, busy, state); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_multi_read_rstart();
    test_reset_mid_byte();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the existing `master` block: detects START/STOP, matches a 7-bit address, ACKs, and then receives write bytes or transmits read bytes.
- Runs entirely on the system clock `clk`; sclk/sda are oversampled, not used as clocks.
- Sits between the I2C bus wires and a simple byte-wide host interface (rx strobe / tx load).

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this target responds to
- SYNC_STAGES, 2, synchronizer flops on sclk and sda inputs (minimum 2)

Ports:
- clk  input  1  system clock, at least 8x the sclk frequency
- rst  input  1  asynchronous reset, active-low (0 = reset)
- sclk  input  1  I2C clock from master
- sda  inout  1  I2C data, open-drain: driven 0 or released to 'z, never driven 1
- tx_data  input  8  byte returned on the next read byte; sampled at the ACK that precedes each read byte
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-clk pulse when rx_data updates
- tx_req  output  1  one-clk pulse when tx_data is sampled
- busy  output  1  high from address match until STOP/START/NACK ends the transfer
- state  output  4  current FSM state, for monitoring

Behaviour:
- Reset (rst=0, async): sda released, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, state=IDLE, bit counter=0.
- Sync: sclk/sda pass SYNC_STAGES flops; edges come from the last two synced samples. Bus-event latency is SYNC_STAGES+1 clk.
- START: synced sda 1->0 while synced sclk=1. Valid from any state, including mid-byte (repeated START): go to ADDR, bit counter=0, release sda.
- STOP: synced sda 0->1 while sclk=1. Valid from any state: go to IDLE, release sda, busy=0.
- Bits are sampled on synced sclk rising edges, MSB first. sda is changed only on the clk after a synced sclk falling edge.
- State encoding: IDLE=0, ADDR=1, ACK_ADDR=2, RX=3, ACK_RX=4, TX=5, WAIT_ACK=6.
- IDLE: sda released; waits for START.
- ADDR: shift in 8 bits (7 address bits + R/W).
  - On address match at the 8th-bit sclk fall: drive sda=0, go to ACK_ADDR, busy=1.
  - On mismatch: go to IDLE; sda stays released for the whole transfer, so the master sees a NACK.
- ACK_ADDR: hold sda=0 through the ACK clock. At that sclk fall:
  - R/W=0: release sda, go to RX.
  - R/W=1: load tx_data into the shift register, pulse tx_req, drive bit7 immediately, go to TX.
- RX: shift 8 bits. At the 8th-bit sclk rise, update rx_data and pulse rx_valid (exactly 1 clk). At that sclk fall, drive sda=0, go to ACK_RX.
- ACK_RX: at the sclk fall, release sda, return to RX. Every byte is ACKed; there is no backpressure.
- TX: drive the shift register MSB: a 0 bit drives sda low, a 1 bit releases sda. Shift at each sclk fall. After the 8th bit's fall, release sda and go to WAIT_ACK.
- WAIT_ACK: sample sda at the sclk rise.
  - sda=0 (ACK): at the following fall, load tx_data, pulse tx_req, drive bit7, go to TX.
  - sda=1 (NACK): go to IDLE, busy=0.
- A START or STOP takes priority over any bit or ACK processing in the same clk.
- sclk stretching is not supported; the block never holds sclk.
- Reset asserted mid-transfer releases sda within the same clk (async).

Test Plan:
- Write: START, 0x84 (addr 0x42, W), byte 0xA5, STOP -> sda=0 on both ACK clocks; rx_data=0xA5; one rx_valid pulse; busy 1 then 0 after STOP; state ends at 0.
- Read: START, 0x85, tx_data=0xF6, master NACKs -> tx_req pulses once; sda bits on the bus are 1,1,1,1,0,1,1,0; state goes 5 -> 6 -> 0.
- Address mismatch: START, 0x86, byte 0x11, STOP -> sda never driven low; rx_valid never pulses; busy stays 0.
- Multi-byte read with ACK, then repeated START: tx_data 0x12 then 0x34 with master ACK on the first byte, then START + 0x84 + 0x5A -> bus carries 0x12 then 0x34; tx_req pulses twice; rx_data=0x5A.
- Reset mid-byte: rst=0 during the 4th bit of a read byte while driving sda=0 -> sda goes 'z immediately; outputs return to reset values; the next START+0x84 transfer works normally.
- Back-to-back writes 0x00, 0xFF, 0x3C -> three rx_valid pulses, each 1 clk; rx_data holds each value until the next byte; all three bytes ACKed.
